// File: rtl/word_store_serializer_pkg.sv
// Shared CPU constants: store FSM encoding and the LH half-select used by
// both the load-side register and the store serializer.
package word_store_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StWrFirst  = 2'b01,
    StWrSecond = 2'b10,
    StDone     = 2'b11
  } store_state_e;

  localparam logic LhLow  = 1'b0;
  localparam logic LhHigh = 1'b1;

endpackage

// File: rtl/word_store_serializer.sv
// Splits a captured 16-bit word into two byte writes (low byte at addr, high
// byte at addr+1) on an 8-bit memory write port, then pulses Done.
module word_store_serializer
  import word_store_serializer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter bit          HIGH_FIRST = 1'b0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [15:0]           WordIn,
  input  logic [ADDR_WIDTH-1:0] AddrIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [7:0]            MemData,
  output logic                  MemWrite,
  output logic                  LH
);

  store_state_e          state_q, state_d;
  logic [15:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  high_phase;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StIdle;
      word_q  <= 16'h0000;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end

  // A new store is only accepted from IDLE or DONE; Start elsewhere is dropped.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          state_d = StWrFirst;
          word_d  = WordIn;
          addr_d  = AddrIn;
        end else begin
          state_d = StIdle;
        end
      end
      StWrFirst:  state_d = StWrSecond;
      StWrSecond: state_d = StDone;
      default:    state_d = StIdle;
    endcase
  end

  assign addr_hi    = addr_q + ADDR_WIDTH'(1);
  assign high_phase = (state_q == StWrSecond) ^ HIGH_FIRST;

  always_comb begin
    Busy     = 1'b0;
    Done     = 1'b0;
    MemWrite = 1'b0;
    MemAddr  = '0;
    MemData  = 8'h00;
    LH       = LhLow;
    unique case (state_q)
      StWrFirst, StWrSecond: begin
        Busy     = 1'b1;
        MemWrite = 1'b1;
        if (high_phase) begin
          MemAddr = addr_hi;
          MemData = word_q[15:8];
          LH      = LhHigh;
        end else begin
          MemAddr = addr_q;
          MemData = word_q[7:0];
          LH      = LhLow;
        end
      end
      StDone:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule
